// File: rtl/instr_fetch_unit_if.sv
// Fetch-side and program-memory-side signals of the instruction fetch unit.
// The slave modport is the fetch unit's view; master is the surrounding system
// (controller plus program memory) that drives requests and memory responses.
interface instr_fetch_unit_if;
  logic        FetchReq;
  logic [6:0]  FetchPC;
  logic        FetchAck;
  logic [15:0] Instr;
  logic        FetchErr;
  logic        Flush;
  logic [7:0]  MemAddr;
  logic        MemRd;
  logic [7:0]  MemRdata;
  logic        MemValid;

  modport slave (
    input  FetchReq, FetchPC, Flush, MemRdata, MemValid,
    output FetchAck, Instr, FetchErr, MemAddr, MemRd
  );

  modport master (
    output FetchReq, FetchPC, Flush, MemRdata, MemValid,
    input  FetchAck, Instr, FetchErr, MemAddr, MemRd
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: two big-endian byte reads per 16-bit word, one-entry last-PC hit register.
// Latency: hit acks 1 cycle after the request is sampled; miss acks 3+Lhi+Llo cycles after.
// Backpressure: FetchReq is a held level sampled only in IDLE; per-byte wait bounded by TIMEOUT.
module instr_fetch_unit #(
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input logic               Clk,
  input logic               Reset,
  instr_fetch_unit_if.slave bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, ACK
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    pc_q, pc_d;
  logic [6:0]    tag_q, tag_d;
  logic          tag_vld_q, tag_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   instr_q, instr_d;
  logic          err_q, err_d;
  logic [7:0]    addr_q, addr_d;
  // fill_q: this fetch completed both reads and may install its tag.
  logic          fill_q, fill_d;
  // flushed_q: a Flush was seen while this miss was in flight.
  logic          flushed_q, flushed_d;

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      instr_q   <= 16'h0000;
      err_q     <= 1'b0;
      addr_q    <= '0;
      fill_q    <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      fill_q    <= fill_d;
      flushed_q <= flushed_d;
    end
  end

  // Next-state logic; Instr/FetchErr are only written on transitions into ACK.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    instr_d   = instr_q;
    err_d     = err_q;
    addr_d    = addr_q;
    fill_d    = fill_q;
    flushed_d = flushed_q | bus.Flush;

    case (state_q)
      IDLE: begin
        fill_d    = 1'b0;
        flushed_d = 1'b0;
        if (bus.FetchReq) begin
          if (tag_vld_q && (bus.FetchPC == tag_q) && !bus.Flush) begin
            err_d   = 1'b0;
            state_d = ACK;
          end else begin
            pc_d      = bus.FetchPC;
            addr_d    = {bus.FetchPC, 1'b0};
            flushed_d = bus.Flush;
            state_d   = HI_REQ;
          end
        end
      end
      HI_REQ: begin
        cnt_d   = '0;
        state_d = HI_WAIT;
      end
      HI_WAIT: begin
        if (bus.MemValid) begin
          hi_d    = bus.MemRdata;
          addr_d  = {pc_q, 1'b1};
          state_d = LO_REQ;
        end else if (cnt_q == CNT_LAST) begin
          instr_d   = NOP_WORD;
          err_d     = 1'b1;
          tag_vld_d = 1'b0;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LO_REQ: begin
        cnt_d   = '0;
        state_d = LO_WAIT;
      end
      LO_WAIT: begin
        if (bus.MemValid) begin
          instr_d = {hi_q, bus.MemRdata};
          err_d   = 1'b0;
          fill_d  = 1'b1;
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          instr_d   = NOP_WORD;
          err_d     = 1'b1;
          tag_vld_d = 1'b0;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (fill_q && !flushed_q) begin
          tag_d     = pc_q;
          tag_vld_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any tag install in the same cycle.
    if (bus.Flush) tag_vld_d = 1'b0;
  end

  // Outputs are pure state decodes or registers, so they are glitch-free.
  always_comb begin
    bus.FetchAck = (state_q == ACK);
    bus.MemRd    = (state_q == HI_REQ) || (state_q == LO_REQ);
    bus.MemAddr  = addr_q;
    bus.Instr    = instr_q;
    bus.FetchErr = err_q;
  end

endmodule
